// File: rtl/eseq_pkg.sv
// Shared definitions for the engagement sequencer: state encodings, state
// width, parameter defaults and the zero-to-one cycle-count helper.
package eseq_pkg;

    localparam int ESEQ_STATE_W = 3;

    typedef enum logic [ESEQ_STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_ARMING   = 3'd1,
        ST_LOCKED   = 3'd2,
        ST_FIRING   = 3'd3,
        ST_COOLDOWN = 3'd4,
        ST_ABORT    = 3'd5
    } eseq_state_e;

    localparam logic [15:0] ESEQ_ARM_CYCLES_DEF        = 16'd4;
    localparam logic [15:0] ESEQ_COOLDOWN_CYCLES_DEF   = 16'd8;
    localparam logic [31:0] ESEQ_MIN_FIRE_DISTANCE_DEF = 32'd100;
    localparam logic [7:0]  ESEQ_MAX_AMMO_DEF          = 8'd6;

    // A programmed duration of zero is treated as a single cycle so a
    // timed state can never be skipped entirely.
    function automatic logic [15:0] eseq_eff_cycles(input logic [15:0] cycles);
        return (cycles == 16'd0) ? 16'd1 : cycles;
    endfunction

endpackage

// File: rtl/eseq_timer.sv
// Shared dwell timer for ARMING and COOLDOWN. Counts up from zero while
// enabled, saturates at 16'hFFFF, and flags done on the last cycle of the
// programmed duration so the FSM leaves on the following edge.
module eseq_timer
    import eseq_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_clear,
    input  logic        i_count_en,
    input  logic [15:0] i_target,
    output logic        o_done
);

    logic [15:0] r_count;
    logic [15:0] w_last;

    // Cycle counter: clear wins over count, never wraps.
    always_ff @(posedge CLK) begin
        if (RST || i_clear) begin
            r_count <= 16'd0;
        end else if (i_count_en && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    // Done while sitting in the final cycle of the effective duration.
    always_comb begin
        w_last = eseq_eff_cycles(i_target) - 16'd1;
        o_done = (r_count >= w_last);
    end

endmodule

// File: rtl/engagement_sequencer.sv
// Engagement sequencer: IDLE -> ARMING -> LOCKED -> FIRING -> COOLDOWN,
// with ABORT reachable from every state. Each cycle an abort condition
// beats a disengage (safe_to_engage low), which beats normal progress.
// All outputs are decoded from the registered state only.
// Optional feature macro: ESEQ_AMMO_TRACK_EN enables ammunition counting;
// without it firing is unlimited and ammo_remaining reads 8'hFF.
module engagement_sequencer
    import eseq_pkg::*;
#(
    parameter logic [15:0] ARM_CYCLES        = ESEQ_ARM_CYCLES_DEF,
    parameter logic [15:0] COOLDOWN_CYCLES   = ESEQ_COOLDOWN_CYCLES_DEF,
    parameter logic [31:0] MIN_FIRE_DISTANCE = ESEQ_MIN_FIRE_DISTANCE_DEF,
    parameter logic [7:0]  MAX_AMMO          = ESEQ_MAX_AMMO_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        safe_to_engage,
    input  logic        emergency_landing_alert,
    input  logic [31:0] distance_to_target,
    input  logic        pilot_fire_cmd,
    input  logic        pilot_abort,
    output logic        fire_pulse,
    output logic        weapon_armed,
    output logic        target_locked,
    output logic        abort_active,
    output logic [2:0]  ESEQ_state,
    output logic [7:0]  ammo_remaining
);

    eseq_state_e r_state;
    eseq_state_e w_next_state;
    logic        r_fire_prev;
    logic        w_abort;
    logic        w_fire_rise;
    logic        w_range_ok;
    logic        w_ammo_ok;
    logic        w_tmr_clear;
    logic        w_tmr_en;
    logic        w_tmr_done;
    logic [15:0] w_tmr_target;

`ifdef ESEQ_AMMO_TRACK_EN
    logic [7:0]  r_ammo;
`endif

    // Qualifying conditions; the fire edge uses the registered previous
    // level so a command held high across entry into LOCKED cannot fire.
    always_comb begin
        w_abort     = emergency_landing_alert | pilot_abort;
        w_fire_rise = pilot_fire_cmd & ~r_fire_prev;
        w_range_ok  = (distance_to_target >= MIN_FIRE_DISTANCE);
`ifdef ESEQ_AMMO_TRACK_EN
        w_ammo_ok   = (r_ammo != 8'd0);
`else
        w_ammo_ok   = 1'b1;
`endif
    end

    // Timer is cleared on every state change and outside timed states, so
    // each visit to ARMING or COOLDOWN starts from zero.
    always_comb begin
        w_tmr_target = (r_state == ST_COOLDOWN) ? COOLDOWN_CYCLES : ARM_CYCLES;
        w_tmr_clear  = (w_next_state != r_state) ||
                       !((r_state == ST_ARMING) || (r_state == ST_COOLDOWN));
        w_tmr_en     = !w_tmr_clear;
    end

    eseq_timer u_timer (
        .CLK        (CLK),
        .RST        (RST),
        .i_clear    (w_tmr_clear),
        .i_count_en (w_tmr_en),
        .i_target   (w_tmr_target),
        .o_done     (w_tmr_done)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Previous-cycle fire command level for rising-edge detection.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_fire_prev <= 1'b0;
        end else begin
            r_fire_prev <= pilot_fire_cmd;
        end
    end

`ifdef ESEQ_AMMO_TRACK_EN
    // One round is spent when leaving FIRING, whichever way it leaves.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ammo <= MAX_AMMO;
        end else if ((r_state == ST_FIRING) && (r_ammo != 8'd0)) begin
            r_ammo <= r_ammo - 8'd1;
        end
    end
`endif

    // Next-state logic with abort > disengage > progress priority.
    always_comb begin
        w_next_state = r_state;
        if (w_abort) begin
            w_next_state = ST_ABORT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (safe_to_engage) w_next_state = ST_ARMING;
                end
                ST_ARMING: begin
                    if (!safe_to_engage)  w_next_state = ST_IDLE;
                    else if (w_tmr_done)  w_next_state = ST_LOCKED;
                end
                ST_LOCKED: begin
                    if (!safe_to_engage)
                        w_next_state = ST_IDLE;
                    else if (w_fire_rise && w_range_ok && w_ammo_ok)
                        w_next_state = ST_FIRING;
                end
                ST_FIRING: begin
                    w_next_state = ST_COOLDOWN;
                end
                ST_COOLDOWN: begin
                    // Disengage only picks the exit; it never cuts the dwell short.
                    if (w_tmr_done)
                        w_next_state = safe_to_engage ? ST_LOCKED : ST_IDLE;
                end
                ST_ABORT: begin
                    w_next_state = ST_IDLE;
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Moore output decode from the registered state.
    always_comb begin
        fire_pulse    = (r_state == ST_FIRING);
        weapon_armed  = (r_state == ST_LOCKED) || (r_state == ST_FIRING) ||
                        (r_state == ST_COOLDOWN);
        target_locked = (r_state == ST_LOCKED);
        abort_active  = (r_state == ST_ABORT);
        ESEQ_state    = r_state;
`ifdef ESEQ_AMMO_TRACK_EN
        ammo_remaining = r_ammo;
`else
        ammo_remaining = 8'hFF;
`endif
    end

endmodule

// File: doc/engagement_sequencer.md
ENGAGEMENT_SEQUENCER -- requirements
Module: engagement_sequencer

Interface
REQ-001 Parameter ARM_CYCLES, 16'd4, cycles in ARMING before lock.
REQ-002 Parameter COOLDOWN_CYCLES, 16'd8, cycles in COOLDOWN after each shot.
REQ-003 Parameter MIN_FIRE_DISTANCE, 32'd100, minimum distance_to_target for firing.
REQ-004 Parameter MAX_AMMO, 8'd6, ammo count loaded at reset.
REQ-005 CLK  input  1  single clock, all state updates on rising edge.
REQ-006 RST  input  1  reset, synchronous, active-high.
REQ-007 safe_to_engage  input  1  engagement permission from the ICMS stage.
REQ-008 emergency_landing_alert  input  1  weather emergency from the ICMS stage.
REQ-009 distance_to_target  input  32  unsigned target distance from the ICMS stage.
REQ-010 pilot_fire_cmd  input  1  level fire request; only rising edges act.
REQ-011 pilot_abort  input  1  manual abort, level.
REQ-012 fire_pulse  output  1  one-cycle weapon release strobe.
REQ-013 weapon_armed  output  1  high in LOCKED, FIRING, COOLDOWN.
REQ-014 target_locked  output  1  high in LOCKED only.
REQ-015 abort_active  output  1  high in ABORT.
REQ-016 ESEQ_state  output  3  current state encoding.
REQ-017 ammo_remaining  output  8  rounds left.

Function
REQ-018 States SHALL be IDLE=0, ARMING=1, LOCKED=2, FIRING=3, COOLDOWN=4, ABORT=5; codes 6-7 SHALL return to IDLE next cycle.
REQ-019 All outputs SHALL be Moore-decoded from registered state; fire_pulse high exactly while state==FIRING.
REQ-020 Priority each cycle: abort condition (emergency_landing_alert or pilot_abort) > disengage (!safe_to_engage) > normal progress.
REQ-021 Any state, abort condition high -> ABORT next cycle; ABORT holds while abort condition high, then -> IDLE one cycle after both inputs low.
REQ-022 IDLE -> ARMING when safe_to_engage high; timer cleared on entry.
REQ-023 ARMING: state SHALL remain ARMING for exactly ARM_CYCLES cycles, then -> LOCKED; safe_to_engage low -> IDLE, timer cleared.
REQ-024 LOCKED -> FIRING when pilot_fire_cmd rising edge AND distance_to_target >= MIN_FIRE_DISTANCE AND ammo_remaining != 0; otherwise hold; safe_to_engage low -> IDLE.
REQ-025 Rising edge SHALL be pilot_fire_cmd high with previous-cycle registered value low; a level held across entry into LOCKED SHALL NOT fire.
REQ-026 FIRING lasts one cycle, then -> COOLDOWN unconditionally unless aborted; ammo decrement on the FIRING->COOLDOWN edge.
REQ-027 COOLDOWN: exactly COOLDOWN_CYCLES cycles, then -> LOCKED if safe_to_engage else IDLE; safe_to_engage low mid-cooldown SHALL NOT shorten cooldown.
REQ-028 Abort during FIRING: fire_pulse already issued counts; ammo still decremented.
REQ-029 Timer 16-bit, saturating; ARM_CYCLES or COOLDOWN_CYCLES of 0 SHALL behave as 1.
REQ-030 ammo_remaining SHALL never wrap below 0.

Reset
REQ-031 RST high at a rising edge: state=IDLE, timer=0, fire-edge register=0, ammo_remaining=MAX_AMMO; all other outputs 0.
REQ-032 RST SHALL override every transition, including mid-FIRING and mid-ABORT.

Configuration
REQ-033 Macro ESEQ_AMMO_TRACK_EN defined: ammo counted per REQ-024/026/030.
REQ-034 Macro undefined: ammo check omitted, unlimited firing, ammo_remaining tied to 8'hFF.

Structure
REQ-035 Shared package eseq_pkg SHALL hold state encodings, state width, and parameter defaults.
REQ-036 One sub-module eseq_timer (load/clear, count, done flag) SHALL serve ARMING and COOLDOWN.

Verification
REQ-037 Reset, safe_to_engage=1 held -> ARMING for 4 cycles, LOCKED on cycle 5, target_locked=1.
REQ-038 LOCKED, distance=150, fire rising edge -> fire_pulse one cycle, ammo 6->5, COOLDOWN 8 cycles, back to LOCKED.
REQ-039 LOCKED, distance=99, fire edge -> no fire_pulse, stays LOCKED; fire held high from ARMING -> no fire.
REQ-040 Six shots then seventh edge -> no fire, ammo_remaining=0 (macro on); macro off -> fires, ammo=8'hFF.
REQ-041 emergency_landing_alert=1 during COOLDOWN -> ABORT next cycle, abort_active=1; clear -> IDLE one cycle later.
REQ-042 RST asserted in FIRING -> IDLE next cycle, ammo=6, fire_pulse=0.
